uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial UART transmitter with an input byte FIFO. It sits at the output of the SoC and takes decoded bytes from the RS decoder path on any cycle where `output_valid && CEO` holds. It buffers those bursts and serialises each byte at a fixed bit period. Its frame format matches the SoC's UART receiver exactly: 1 start bit, 8 data bits LSB first, an even-parity bit, and 1 stop bit, with the line idling high.

## Interface
- `CLKS_PER_BIT`, 864: clock cycles per serial bit (100 MHz clk, 8640 ns bit); must be ≥ 2.
- `FIFO_DEPTH`, 256: byte FIFO depth; must be a power of 2 and ≥ 4. The default holds one 188-byte decoded block.
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  byte to transmit.
- `tx_valid`  in  1  write strobe; `tx_data` is sampled when this is high.
- `Tx_D`  out  1  serial line; idles high.
- `fifo_full`  out  1  high when the FIFO holds `FIFO_DEPTH` bytes.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `busy`  out  1  high while a frame is on the line.
- `tx_done`  out  1  one-cycle pulse in the cycle after a stop bit completes.
- `overflow`  out  1  sticky flag, set when a write is dropped; cleared only by reset.

## Operation
- **Reset values:** `Tx_D`=1, `busy`=0, `tx_done`=0, `overflow`=0, `fifo_full`=0, `fifo_count`=0. FIFO pointers are 0 and the FSM is in IDLE.
- **FSM states:** IDLE → START → DATA → PARITY → STOP → (IDLE or START).
- **IDLE:** `Tx_D`=1. If the FIFO is non-empty, pop the head into shift register `sh`, compute `par` = ^byte (even parity), and go to START.
- **START:** `Tx_D`=0 for `CLKS_PER_BIT` cycles.
- **DATA:** `Tx_D`=`sh[0]`. Every `CLKS_PER_BIT` cycles, shift `sh` right and increment the 3-bit bit index. After bit 7 completes, go to PARITY.
- **PARITY:** `Tx_D`=`par` for `CLKS_PER_BIT` cycles.
- **STOP:** `Tx_D`=1 for `CLKS_PER_BIT` cycles. In the last cycle of STOP:
  - if the FIFO is non-empty, pop the next byte and go directly to START (no idle gap);
  - otherwise go to IDLE.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1 and clears on every state change. It is $clog2(`CLKS_PER_BIT`) bits wide.
- **`busy`:** 1 in START, DATA, PARITY and STOP.
- **Writes:**
  - When `tx_valid`=1 and the FIFO is not full, the byte is written at the tail.
  - When the FIFO is full and a pop occurs in the same cycle, the write is accepted and `fifo_count` is unchanged.
  - When the FIFO is full and no pop occurs, the byte is dropped and `overflow` is set.
- **Simultaneous push and pop (not full):** `fifo_count` is unchanged.
- **Pointer wrap:** read and write pointers wrap modulo `FIFO_DEPTH` naturally.
- **Reset mid-frame:** the frame is aborted, `Tx_D` returns to 1 on the next edge, and FIFO contents are discarded.

## Timing
- **Latency:** `tx_valid` sampled at edge N with the FIFO empty and the FSM in IDLE gives `fifo_count`=1 after N, pop at N+1, and `Tx_D` falling after edge N+2.
- **Frame length:** exactly 11×`CLKS_PER_BIT` cycles. Each bit lasts exactly `CLKS_PER_BIT` cycles.
- **Back-to-back frames:** consecutive frames are contiguous, so a block of K bytes takes K×11×`CLKS_PER_BIT` cycles.
- **`tx_done`:** asserted for one cycle, in the first cycle after STOP, whether the next state is START or IDLE.
- **Flag timing:** `fifo_full` and `fifo_count` are registered and reflect state after the current edge. `fifo_full` is asserted combinationally from `fifo_count`.
- **Write rate:** any rate up to one write per cycle is accepted.

## Structure
- Shared package `uart_pkg` holds:
  - the `CLKS_PER_BIT` default (864);
  - the frame constants `START_BIT`=0 and `STOP_BIT`=1;
  - the data-bit count, 8;
  - the state enum {IDLE, START, DATA, PARITY, STOP}.
  The UART receiver uses the same package so framing cannot diverge.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH) provides push/pop/full/empty/count with the full-plus-pop rule above.
- The transmitter FSM, baud counter and shift register live in `uart_transmitter`.

## Test plan
- **Single byte:** with `CLKS_PER_BIT`=4, write 0xA5 once. `Tx_D` must read 0,1,0,1,0,0,1,0,1,0,1, each bit for 4 cycles (parity 0 because 0xA5 has four ones). `tx_done` pulses once and `busy` drops after 44 cycles.
- **Odd-weight parity:** write 0x07. The parity bit must be 1.
- **Back-to-back:** write 0x00, 0xFF, 0x3C on three consecutive cycles. Three contiguous frames must occupy exactly 132 cycles with no idle-high gap. `fifo_count` peaks at 2, since the first byte is popped before the third write.
- **Overflow and full-plus-pop:** with `FIFO_DEPTH`=4 and the FSM mid-frame, write 6 bytes consecutively. `fifo_full`=1 after 4 writes, bytes 5 and 6 are dropped, and `overflow`=1. In a second run, write while full in the pop cycle: the write is accepted and `overflow` stays 0.
- **Reset mid-frame:** assert `reset` during DATA bit 3. On the next edge `Tx_D`=1, `busy`=0 and `fifo_count`=0, and no further frames are sent.
- **Loopback:** at default parameters, connect `Tx_D` to the SoC UART receiver and feed 188 bytes from `output_RS_blocks`. All received bytes must match in order with zero errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Framing constants and FSM state type shared by the UART transmitter and receiver,
// so that both ends always agree on the frame layout.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 864;
    localparam int DATA_BITS            = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_transmitter_sync_fifo.sv
// Single-clock FIFO with registered occupancy; a push into a full FIFO is still
// accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: byte FIFO feeding a 1 start / 8 data / even parity / 1 stop serialiser.
//   state  | meaning
//   IDLE   | line high, waiting for a byte in the FIFO
//   START  | start bit on the line
//   DATA   | data bits, LSB first
//   PARITY | even parity bit
//   STOP   | stop bit; last cycle pops the next byte for a gapless frame
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          Tx_D,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          tx_done,
    output logic                          overflow
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          tx_done_q, tx_done_d;
    logic          overflow_q, overflow_d;
    logic          bit_end;
    logic          pop;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tx_valid),
        .wdata_i (tx_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        sh_d       = sh_q;
        par_d      = par_q;
        pop        = 1'b0;
        baud_d     = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
        tx_done_d  = (state_q == STOP) && bit_end;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sh_d    = fifo_rdata;
                    par_d   = ^fifo_rdata;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    sh_d      = sh_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = PARITY;
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        sh_d    = fifo_rdata;
                        par_d   = ^fifo_rdata;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered, so it trails the state by one cycle.
        case (state_q)
            START:   tx_d = START_BIT;
            DATA:    tx_d = sh_q[0];
            PARITY:  tx_d = par_q;
            STOP:    tx_d = STOP_BIT;
            default: tx_d = 1'b1;
        endcase

        overflow_d = overflow_q | (tx_valid && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            sh_q       <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            sh_q       <= sh_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
            overflow_q <= overflow_d;
        end
    end

    assign Tx_D     = tx_q;
    assign busy     = (state_q != IDLE);
    assign tx_done  = tx_done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with a short bit period and a 4-deep FIFO.
module tb_uart_transmitter;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 11 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       Tx_D;
    logic       fifo_full;
    logic [$clog2(DEPTH):0] fifo_count;
    logic       busy;
    logic       tx_done;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_transmitter #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .Tx_D       (Tx_D),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .busy       (busy),
        .tx_done    (tx_done),
        .overflow   (overflow)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input logic p, input int i);
        if (i == 0)      return 1'b0;
        else if (i <= 8) return d[i-1];
        else if (i == 9) return p;
        else             return 1'b1;
    endfunction

    task automatic do_reset();
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int         done_cnt;
        int         peak;
        logic [7:0] bb   [3];
        logic       bpar [3];
        logic       quiet;

        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h3C, 1'b0};
        vecs[5] = '{8'h80, 1'b1};
        vecs[6] = '{8'h01, 1'b1};
        vecs[7] = '{8'h5A, 1'b0};

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        @(negedge clk);
        do_reset();
        check("rst_txd",      Tx_D,       1);
        check("rst_busy",     busy,       0);
        check("rst_done",     tx_done,    0);
        check("rst_overflow", overflow,   0);
        check("rst_full",     fifo_full,  0);
        check("rst_count",    fifo_count, 0);

        // Single frames: line pattern, busy window and one tx_done pulse.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            tx_data  = vecs[v].data;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            check("count_after_write", fifo_count, 1);
            check("line_idle_after_write", Tx_D, 1);
            @(negedge clk);
            check("busy_after_pop", busy, 1);
            check("line_high_before_start", Tx_D, 1);
            check("count_after_pop", fifo_count, 0);
            done_cnt = 0;
            for (int k = 0; k < FRAME; k++) begin
                @(negedge clk);
                check($sformatf("v%0d_bit%0d", v, k / CPB), Tx_D,
                      frame_bit(vecs[v].data, vecs[v].par, k / CPB));
                check($sformatf("v%0d_busy_k%0d", v, k), busy, (k < FRAME - 1) ? 1 : 0);
                check($sformatf("v%0d_done_k%0d", v, k), tx_done, (k == FRAME - 1) ? 1 : 0);
                if (tx_done) done_cnt++;
            end
            check("tx_done_pulses", done_cnt, 1);
            @(negedge clk);
            check("line_idle_after_frame", Tx_D, 1);
            check("busy_after_frame", busy, 0);
            check("done_after_frame", tx_done, 0);
        end

        // Back-to-back: three writes on consecutive cycles, 132 contiguous frame cycles.
        bb[0] = 8'h00; bpar[0] = 1'b0;
        bb[1] = 8'hFF; bpar[1] = 1'b0;
        bb[2] = 8'h3C; bpar[2] = 1'b0;
        do_reset();
        peak = 0;
        tx_valid = 1'b1;
        tx_data  = bb[0];
        @(negedge clk);
        check("b2b_count_1", fifo_count, 1);
        tx_data = bb[1];
        @(negedge clk);
        check("b2b_count_2", fifo_count, 1);
        tx_data = bb[2];
        @(negedge clk);
        tx_valid = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            check($sformatf("b2b_bit_k%0d", k), Tx_D,
                  frame_bit(bb[k / FRAME], bpar[k / FRAME], (k % FRAME) / CPB));
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (tx_done) done_cnt++;
            @(negedge clk);
        end
        check("b2b_line_idle_after", Tx_D, 1);
        check("b2b_busy_after", busy, 0);
        check("b2b_peak_count", peak, 2);
        check("b2b_done_pulses", done_cnt, 3);

        // Overflow: six writes mid-frame into a 4-deep FIFO.
        do_reset();
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            tx_valid = 1'b1;
            tx_data  = 8'h20 + 8'(i);
            @(negedge clk);
            if (i < 3) check($sformatf("ovf_not_full_%0d", i), fifo_full, 0);
            if (i == 3) begin
                check("ovf_full_after_4", fifo_full, 1);
                check("ovf_count_after_4", fifo_count, 4);
                check("ovf_flag_after_4", overflow, 0);
            end
        end
        tx_valid = 1'b0;
        check("ovf_flag", overflow, 1);
        check("ovf_count", fifo_count, 4);
        check("ovf_full", fifo_full, 1);

        // Full plus pop: a write in the pop cycle is accepted without overflow.
        do_reset();
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tx_data = 8'h40 + 8'(i);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("fpp_count_full", fifo_count, 4);
        check("fpp_full", fifo_full, 1);
        repeat (40) @(negedge clk);
        check("fpp_ovf_before", overflow, 0);
        tx_valid = 1'b1;
        tx_data  = 8'h99;
        @(negedge clk);
        tx_valid = 1'b0;
        check("fpp_count_same", fifo_count, 4);
        check("fpp_ovf_stays_0", overflow, 0);
        check("fpp_done_pulse", tx_done, 1);
        tx_valid = 1'b1;
        tx_data  = 8'h9A;
        @(negedge clk);
        tx_valid = 1'b0;
        check("fpp_ovf_no_pop", overflow, 1);
        check("fpp_count_no_pop", fifo_count, 4);

        // Reset during data bit 3 aborts the frame and empties the FIFO.
        do_reset();
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        @(negedge clk);
        tx_data = 8'h3C;
        @(negedge clk);
        tx_valid = 1'b0;
        check("rmf_count_queued", fifo_count, 1);
        repeat (17) @(negedge clk);
        check("rmf_bit3_before_reset", Tx_D, 0);
        check("rmf_busy_before_reset", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rmf_txd", Tx_D, 1);
        check("rmf_busy", busy, 0);
        check("rmf_count", fifo_count, 0);
        quiet = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (Tx_D !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        check("rmf_no_more_frames", quiet, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
